// File: rtl/c2_chunk_sequencer_if.sv
// Requester/consumer bundle for the chunked two's complement negator.
// master: drives start/din, sees ready/busy/done/dout/cout/ovf.
// slave : the sequencer side of the same signals.
interface c2_chunk_sequencer_if #(
    parameter int W = 24
);
    logic         start;
    logic [W-1:0] din;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic         cout;
    logic         ovf;

    modport master (
        output start, din,
        input  ready, busy, done,
        input  dout, cout, ovf
    );

    modport slave (
        input  start, din,
        output ready, busy, done,
        output dout, cout, ovf
    );
endinterface

// File: rtl/c2_chunk_sequencer.sv
// Wide two's complement negation, one CHUNK-bit slice per clock,
// carry chained LSB chunk first.
// Ports: clk, reset (sync, active-high), bus (slave modport):
//   start/din in; ready/busy/done, dout/cout/ovf out.
module c2_chunk_sequencer #(
    parameter int CHUNK  = 6,
    parameter int NCHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    c2_chunk_sequencer_if.slave bus
);
    localparam int W  = CHUNK * NCHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
    localparam logic [W-1:0]  MINV = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   operand;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_nxt;
    logic [IW-1:0]  idx;
    logic           carry;
    logic           carry_nxt;
    logic [CHUNK-1:0] slice;
    logic [CHUNK-1:0] res;
    logic           last;
    logic           accept;

    assign slice = operand[idx*CHUNK +: CHUNK];
    assign res   = ~slice + {{(CHUNK-1){1'b0}}, carry};
    assign last  = (idx == LAST);

    // The carry only survives an all-zero slice.
    assign carry_nxt = carry & (slice == '0);

    // Merge the freshly computed chunk so the final edge can
    // publish the complete word directly.
    always_comb begin
        acc_nxt = acc;
        acc_nxt[idx*CHUNK +: CHUNK] = res;
    end

    assign accept = bus.start & (state != RUN);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            operand  <= '0;
            acc      <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            bus.dout <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else if (accept) begin
            operand <= bus.din;
            acc     <= '0;
            idx     <= '0;
            carry   <= 1'b1;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            carry <= carry_nxt;
            idx   <= idx + IW'(1);
            if (last) begin
                bus.dout <= acc_nxt;
                bus.cout <= carry_nxt;
                bus.ovf  <= (operand == MINV);
            end
        end
    end

    assign bus.ready = (state != RUN);
    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
endmodule
